// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and widths for the 4:1 mux scan controller
package mux_scan_pkg;

  localparam int NCH      = 4;
  localparam int CH_W     = 2;
  localparam int SETTLE_W = 4;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_timer.sv
// rtl/mux_scan_timer.sv - per-channel settle dwell counter
// load_i reloads SETTLE; expire_o is high in the last cycle of the dwell window.
module mux_scan_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic expire_o
);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = SETTLE_W'(SETTLE);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans the four mux inputs in turn and publishes them as one word
// Channel bits gather in a shadow and are copied to DATA in a single edge.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CONT,
  input  logic             M1,
  output logic             EN,
  output logic             S0,
  output logic             S1,
  output logic             BUSY,
  output logic             DONE,
  output logic [NCH-1:0]   DATA,
  output logic [CNT_W-1:0] SCAN_CNT
);

  state_e           state_q;
  logic [CH_W-1:0]  ch_q;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0]   data_q;
  logic [CNT_W-1:0] scan_cnt_q;
  logic             en_q, busy_q, done_q, cont_q;
  logic             timer_load, timer_expire;

  mux_scan_timer #(.SETTLE(SETTLE)) u_timer (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (timer_load),
    .expire_o (timer_expire)
  );

  always_comb begin
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE: timer_load = START;
      ST_SCAN: timer_load = timer_expire;
      ST_DONE: timer_load = cont_q;
      default: timer_load = 1'b0;
    endcase
  end

  // Shadow including the bit being captured this edge, so DATA gets all four at once.
  always_comb begin
    shadow_d       = shadow_q;
    shadow_d[ch_q] = M1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      shadow_q   <= '0;
      data_q     <= '0;
      scan_cnt_q <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cont_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            state_q <= ST_SCAN;
            ch_q    <= '0;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (timer_expire) begin
            shadow_q <= shadow_d;
            ch_q     <= ch_q + CH_W'(1);
            if (ch_q == CH_W'(NCH - 1)) begin
              data_q     <= shadow_d;
              scan_cnt_q <= scan_cnt_q + CNT_W'(1);
              cont_q     <= CONT;
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              en_q       <= 1'b0;
              busy_q     <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          ch_q   <= '0;
          if (cont_q) begin
            state_q <= ST_SCAN;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ch_q    <= '0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign EN       = en_q;
  assign S0       = ch_q[0] & en_q;
  assign S1       = ch_q[1] & en_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign DATA     = data_q;
  assign SCAN_CNT = scan_cnt_q;

endmodule
